// File: rtl/int8_mlp_pkg.sv
// Shared types and helpers for the int8 MLP datapath.
// Holds operand/product types, the MAC FSM states and the signed-overflow check.
package int8_mlp_pkg;

  localparam int PROD_W = 16;

  typedef logic signed [7:0] int8_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } mac_state_e;

  // Two's complement add overflows when the operands agree
  // in sign and the sum does not; arguments are sign bits.
  function automatic logic sadd_ovf(
    input logic a,
    input logic b,
    input logic sum
  );
    return (a == b) && (sum != a);
  endfunction

endpackage

// File: rtl/int8_lane_sum.sv
// Lane-wise int8 multiply plus reduction, sign-extended to ACC_W.
// Purely combinational; the top registers everything.
module int8_lane_sum
  import int8_mlp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic signed [7:0]       x [LANES],
  input  logic signed [7:0]       w [LANES],
  output logic signed [ACC_W-1:0] sum
);

  prod_t prod [LANES];

  // Full 16-bit signed products so -128*-128 stays exact,
  // each widened before the reduction to avoid intermediate wrap.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i] = prod_t'(x[i]) * prod_t'(w[i]);
      sum     = sum + ACC_W'(prod[i]);
    end
  end

endmodule

// File: rtl/int8_mac_stream.sv
// Streaming int8 dot-product engine: accumulates beats until last, then holds one result.
// Optional INT8_MAC_BIAS_EN adds a bias port that preloads the accumulator.
module int8_mac_stream
  import int8_mlp_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_x [LANES],
  input  logic signed [7:0]       in_w [LANES],
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf
`ifdef INT8_MAC_BIAS_EN
  ,
  input  logic signed [ACC_W-1:0] bias
`endif
);

  mac_state_e state;
  mac_state_e state_nxt;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] beat_sum;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] start_val;
  logic                    ovf_sticky;
  logic                    beat_ovf;
  logic                    fire;

`ifdef INT8_MAC_BIAS_EN
  assign start_val = bias;
`else
  assign start_val = '0;
`endif

  int8_lane_sum #(
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) u_lane_sum (
    .x   (in_x),
    .w   (in_w),
    .sum (beat_sum)
  );

  assign fire     = in_valid && in_ready;
  assign acc_sum  = acc + beat_sum;
  assign beat_ovf = sadd_ovf(acc[ACC_W-1],
                             beat_sum[ACC_W-1],
                             acc_sum[ACC_W-1]);

  assign out_valid = (state == HOLD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  // Next state and input handshake; HOLD blocks new beats.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Accumulator, sticky overflow and the held result; the
  // accumulator reloads its start value as each result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= start_val;
      ovf_sticky <= 1'b0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
    end else if (fire) begin
      if (in_last) begin
        out_acc    <= acc_sum;
        out_ovf    <= ovf_sticky | beat_ovf;
        acc        <= start_val;
        ovf_sticky <= 1'b0;
      end else begin
        acc        <= acc_sum;
        ovf_sticky <= ovf_sticky | beat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_int8_mac_stream.sv
// Bench for int8_mac_stream: a LANES=4/ACC_W=32 instance and a LANES=1/ACC_W=16 instance.
// Expected results come from a plain-arithmetic dot-product model; honours INT8_MAC_BIAS_EN.
module tb_int8_mac_stream;

  localparam int AL = 4;
  localparam int AW = 32;
  localparam int BL = 1;
  localparam int BW = 16;

`ifdef INT8_MAC_BIAS_EN
  localparam longint A_BIAS = -100;
  localparam longint B_BIAS = 0;
`else
  localparam longint A_BIAS = 0;
  localparam longint B_BIAS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 a_in_valid, a_in_ready, a_in_last;
  logic                 a_out_valid, a_out_ready, a_out_ovf;
  logic signed [7:0]    a_x [AL];
  logic signed [7:0]    a_w [AL];
  logic signed [AW-1:0] a_out_acc;

  logic                 b_in_valid, b_in_ready, b_in_last;
  logic                 b_out_valid, b_out_ready, b_out_ovf;
  logic signed [7:0]    b_x [BL];
  logic signed [7:0]    b_w [BL];
  logic signed [BW-1:0] b_out_acc;

`ifdef INT8_MAC_BIAS_EN
  logic signed [AW-1:0] a_bias;
  logic signed [BW-1:0] b_bias;
  assign a_bias = AW'(A_BIAS);
  assign b_bias = BW'(B_BIAS);
`endif

  int8_mac_stream #(.LANES(AL), .ACC_W(AW)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_x      (a_x),
    .in_w      (a_w),
    .in_last   (a_in_last),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_acc   (a_out_acc),
    .out_ovf   (a_out_ovf)
`ifdef INT8_MAC_BIAS_EN
    ,
    .bias      (a_bias)
`endif
  );

  int8_mac_stream #(.LANES(BL), .ACC_W(BW)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_x      (b_x),
    .in_w      (b_w),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_acc   (b_out_acc),
    .out_ovf   (b_out_ovf)
`ifdef INT8_MAC_BIAS_EN
    ,
    .bias      (b_bias)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reduce an exact integer to its ACC_W-bit two's complement value.
  function automatic longint wrapw(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v % m;
    if (r >= m / 2) r -= m;
    else if (r < -(m / 2)) r += m;
    return r;
  endfunction

  // Reference state: running wrapped sum and whether any partial
  // sum left the representable range.
  longint a_m_acc, a_exp_acc;
  bit     a_m_ovf, a_exp_ovf;
  longint b_m_acc, b_exp_acc;
  bit     b_m_ovf, b_exp_ovf;

  task automatic a_beat(input bit last);
    longint s;
    longint t;
    int n;
    s = 0;
    n = 0;
    a_in_valid = 1'b1;
    a_in_last  = last;
    while (!a_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("a_ready_wait", a_in_ready, 1);
    for (int i = 0; i < AL; i++)
      s += longint'(a_x[i]) * longint'(a_w[i]);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    t = a_m_acc + s;
    if (t != wrapw(t, AW)) a_m_ovf = 1'b1;
    a_m_acc = wrapw(t, AW);
    if (last) begin
      a_exp_acc = a_m_acc;
      a_exp_ovf = a_m_ovf;
      a_m_acc   = A_BIAS;
      a_m_ovf   = 1'b0;
      check("a_latency", a_out_valid, 1);
    end else begin
      check("a_early_valid", a_out_valid, 0);
    end
    for (int i = 0; i < AL; i++) begin
      a_x[i] = 8'($urandom);
      a_w[i] = 8'($urandom);
    end
    a_in_last = 1'($urandom);
  endtask

  task automatic a_result(input int hold);
    check("a_acc", a_out_acc, a_exp_acc);
    check("a_ovf", a_out_ovf, a_exp_ovf);
    a_out_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      check("a_hold_valid", a_out_valid, 1);
      check("a_hold_in_ready", a_in_ready, 0);
      check("a_hold_acc", a_out_acc, a_exp_acc);
      check("a_hold_ovf", a_out_ovf, a_exp_ovf);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("a_drain_valid", a_out_valid, 0);
    check("a_drain_in_ready", a_in_ready, 1);
  endtask

  task automatic b_beat(input int xv, input int wv, input bit last);
    longint t;
    int n;
    n = 0;
    b_x[0] = 8'(xv);
    b_w[0] = 8'(wv);
    b_in_valid = 1'b1;
    b_in_last  = last;
    while (!b_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("b_ready_wait", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    t = b_m_acc + longint'(xv) * longint'(wv);
    if (t != wrapw(t, BW)) b_m_ovf = 1'b1;
    b_m_acc = wrapw(t, BW);
    if (last) begin
      b_exp_acc = b_m_acc;
      b_exp_ovf = b_m_ovf;
      b_m_acc   = B_BIAS;
      b_m_ovf   = 1'b0;
      check("b_latency", b_out_valid, 1);
    end
    b_x[0] = 8'($urandom);
    b_w[0] = 8'($urandom);
  endtask

  task automatic b_result(input int hold);
    check("b_acc", b_out_acc, b_exp_acc);
    check("b_ovf", b_out_ovf, b_exp_ovf);
    repeat (hold) begin
      @(posedge clk); #1;
      check("b_hold_acc", b_out_acc, b_exp_acc);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check("b_drain_valid", b_out_valid, 0);
  endtask

  task automatic a_fill(input int xv, input int wv);
    for (int i = 0; i < AL; i++) begin
      a_x[i] = 8'(xv);
      a_w[i] = 8'(wv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    rst = 1'b1;
    a_in_valid = 0; a_in_last = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_out_ready = 0;
    a_fill(0, 0);
    b_x[0] = 0; b_w[0] = 0;
    a_m_acc = A_BIAS; a_m_ovf = 0;
    b_m_acc = B_BIAS; b_m_ovf = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_acc", a_out_acc, 0);
    check("rst_out_ovf", a_out_ovf, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single beat, 1*5+2*6+3*7+4*8.
    for (int i = 0; i < AL; i++) begin
      a_x[i] = 8'(i + 1);
      a_w[i] = 8'(i + 5);
    end
    a_beat(1);
    check("one_beat_const", a_out_acc, 70 + A_BIAS);
    a_result(0);

    // Three beats of the most negative operands.
    for (int b = 0; b < 3; b++) begin
      a_fill(-128, -128);
      a_beat(b == 2);
    end
    check("neg_const", a_out_acc, 196608 + A_BIAS);
    a_result(1);

    // Back-pressure with a beat waiting at the input.
    a_fill(3, 3);
    a_beat(1);
    a_fill(2, 2);
    a_in_valid = 1'b1;
    a_in_last  = 1'b1;
    a_result(5);
    a_beat(1);
    check("held_beat_const", a_out_acc, 16 + A_BIAS);
    a_result(0);

    // Narrow instance: wrap, sticky overflow, clearing.
    b_beat(127, 127, 0);
    b_beat(127, 127, 0);
    b_beat(127, 127, 1);
    check("b_wrap_const", b_out_acc, -17149);
    b_result(2);
    b_beat(1, 1, 1);
    check("b_ovf_cleared", b_out_ovf, 0);
    b_result(0);
    b_beat(-128, -128, 0);
    b_beat(-128, -128, 1);
    check("b_min_const", b_out_acc, -32768);
    b_result(0);
    b_beat(127, 127, 0);
    b_beat(127, 127, 0);
    b_beat(127, 127, 0);
    b_beat(-128, 127, 1);
    check("b_sticky_const", b_out_ovf, 1);
    b_result(0);
    b_beat(127, 127, 0);
    b_beat(127, 127, 1);
    b_result(0);

    // Abort mid-stream, then abort a pending result.
    for (int b = 0; b < 2; b++) begin
      a_fill(int'($urandom_range(0, 255)) - 128, 7);
      a_beat(0);
    end
    b_beat(100, 100, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a_m_acc = A_BIAS; a_m_ovf = 0;
    b_m_acc = B_BIAS; b_m_ovf = 0;
    check("abort_valid", a_out_valid, 0);
    check("abort_in_ready", a_in_ready, 1);
    a_fill(2, 2);
    a_beat(1);
    check("after_abort_const", a_out_acc, 16 + A_BIAS);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("drop_valid", a_out_valid, 0);
    check("drop_acc", a_out_acc, 0);
    a_fill(1, 1);
    a_beat(1);
    a_result(0);
    b_beat(5, -3, 1);
    b_result(0);

    // Random streams with idle gaps and back-pressure.
    for (int s = 0; s < 12; s++) begin
      nb = int'($urandom_range(1, 6));
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < AL; i++) begin
          a_x[i] = 8'($urandom);
          a_w[i] = 8'($urandom);
        end
        a_beat(b == nb - 1);
        if (b != nb - 1)
          repeat (int'($urandom_range(0, 2))) begin
            @(posedge clk); #1;
          end
      end
      a_result(int'($urandom_range(0, 3)));
    end
    for (int s = 0; s < 12; s++) begin
      nb = int'($urandom_range(1, 5));
      for (int b = 0; b < nb; b++)
        b_beat(int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128,
               b == nb - 1);
      b_result(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
